// File: rtl/alu_pkg.sv
// Shared encodings for the nibble-serial add/sub ALU: opcodes, FSM states, slice width.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit ripple adder; exposes the carry into the top bit so the
// controller can form signed overflow on the final nibble.
module nibble_addsub_slice
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequencer that runs one 4-bit add/sub slice across a WIDTH-bit operand pair,
// LSB nibble first, with a valid/ready request and response handshake.
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic                 carry_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [WIDTH-1:0]     rsp_result_reg;
  logic                 rsp_cout_reg, rsp_zero_reg, rsp_ovf_reg;

  logic [NIBBLE_W-1:0]  a_nib [NIBBLES];
  logic [NIBBLE_W-1:0]  b_nib [NIBBLES];
  logic [NIBBLE_W-1:0]  acc_nib_reg [NIBBLES-1];
  logic [WIDTH-1:0]     result_full;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_cout, slice_c3;
  logic                 accept, running, last_nib;

  assign accept   = req_valid && (state_reg == ST_IDLE);
  assign running  = (state_reg == ST_RUN);
  assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
      if (gi < NIBBLES - 1) begin : g_acc
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            acc_nib_reg[gi] <= '0;
          else if (running && idx_reg == IDX_W'(gi))
            acc_nib_reg[gi] <= slice_s;
        end
        assign result_full[gi*NIBBLE_W +: NIBBLE_W] = acc_nib_reg[gi];
      end else begin : g_top
        // Top nibble goes straight from the slice into the response register.
        assign result_full[gi*NIBBLE_W +: NIBBLE_W] = slice_s;
      end
    end
  endgenerate

  nibble_addsub_slice u_slice (
    .a    (a_nib[idx_reg]),
    .b    (b_nib[idx_reg]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = ST_RUN;
      ST_RUN:  if (last_nib)  state_next = ST_DONE;
      ST_DONE: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      carry_reg      <= 1'b0;
      idx_reg        <= '0;
      rsp_result_reg <= '0;
      rsp_cout_reg   <= 1'b0;
      rsp_zero_reg   <= 1'b0;
      rsp_ovf_reg    <= 1'b0;
    end else if (accept) begin
      a_reg     <= req_a;
      // Subtraction is A + ~B + cin; SUB forces cin=1, ADD forces cin=0.
      b_reg     <= req_op[1] ? ~req_b : req_b;
      carry_reg <= req_op[0] ? req_cin : req_op[1];
      idx_reg   <= '0;
    end else if (running) begin
      carry_reg <= slice_cout;
      idx_reg   <= last_nib ? '0 : idx_reg + 1'b1;
      if (last_nib) begin
        rsp_result_reg <= result_full;
        rsp_cout_reg   <= slice_cout;
        rsp_zero_reg   <= ~|result_full;
        rsp_ovf_reg    <= slice_cout ^ slice_c3;
      end
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign rsp_valid  = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);
  assign rsp_result = rsp_result_reg;
  assign rsp_cout   = rsp_cout_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_ovf    = rsp_ovf_reg;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl with hand-computed expected results.
module tb_nibble_serial_alu_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             req_cin = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout, rsp_zero, rsp_ovf, busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, ".busy"},      32'(busy),      32'd0);
    check_val({tag, ".result"},    32'(rsp_result), 32'h0);
    check_val({tag, ".flags"},     {29'd0, rsp_cout, rsp_zero, rsp_ovf}, 32'd0);
  endtask

  // Issue one request, wait for the response and check latency and results.
  // With hold=1 the response is left pending in DONE (rsp_ready stays as driven).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] exp_res,
                       input logic exp_cout, input logic exp_zero, input logic exp_ovf,
                       input bit hold);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    check_val({tag, ".ready_before"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_cin = ~cin;
    lat = 0;
    rdy_seen = 1'b0;
    while (!rsp_valid && lat < 20) begin
      if (req_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_val({tag, ".latency"},   32'(lat),        32'd4);
    check_val({tag, ".ready_run"}, 32'(rdy_seen),   32'd0);
    check_val({tag, ".result"},    32'(rsp_result), 32'(exp_res));
    check_val({tag, ".flags"}, {29'd0, rsp_cout, rsp_zero, rsp_ovf},
              {29'd0, exp_cout, exp_zero, exp_ovf});
    $display("txn %s op=%0d a=%h b=%h cin=%0d -> res=%h c=%0d z=%0d v=%0d lat=%0d",
             tag, op, a, b, cin, rsp_result, rsp_cout, rsp_zero, rsp_ovf, lat);
    if (!hold) begin
      @(negedge clk);
      check_val({tag, ".valid_fall"}, 32'(rsp_valid), 32'd0);
      check_val({tag, ".result_kept"}, 32'(rsp_result), 32'(exp_res));
    end
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add1",   2'b00, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub1",   2'b10, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_eq", 2'b10, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("add_ov", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("add_wr", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("adc1",   2'b01, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sbc1",   2'b11, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sbc0",   2'b11, 16'h8000, 16'h0001, 1'b0, 16'h7FFE, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("add_ci", 2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_ci", 2'b10, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: response held in DONE while new requests are offered.
    rsp_ready = 1'b0;
    do_op("bp", 2'b00, 16'h00A0, 16'h000B, 1'b0, 16'h00AB, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = 2'b10; req_a = 16'(16'h5000 + i); req_b = 16'h0123;
      @(negedge clk);
      check_val($sformatf("bp_hold%0d.valid", i),  32'(rsp_valid),  32'd1);
      check_val($sformatf("bp_hold%0d.busy", i),   32'(busy),       32'd1);
      check_val($sformatf("bp_hold%0d.ready", i),  32'(req_ready),  32'd0);
      check_val($sformatf("bp_hold%0d.result", i), 32'(rsp_result), 32'h00AB);
      $display("txn bp_hold%0d valid=%0d busy=%0d res=%h", i, rsp_valid, busy, rsp_result);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("bp_rel.valid",  32'(rsp_valid),  32'd0);
    check_val("bp_rel.busy",   32'(busy),       32'd0);
    check_val("bp_rel.ready",  32'(req_ready),  32'd1);
    check_val("bp_rel.result", 32'(rsp_result), 32'h00AB);
    do_op("post_bp", 2'b10, 16'h0300, 16'h0100, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN, two nibbles in.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 16'h1111; req_b = 16'h2222;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    $display("txn midrst valid=%0d busy=%0d res=%h", rsp_valid, busy, rsp_result);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("midrst_hold%0d.valid", i), 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    do_op("post_rst", 2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
Multi-cycle sequencer that time-multiplexes one 4-bit add/sub slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first. The carry is held in a register between nibbles. Serves the SimpleCPU execute stage as a narrow-datapath ALU for ADD/ADC/SUB/SBC. Uses a valid/ready request/response handshake and produces carry, zero and signed-overflow flags.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived; number of slice passes per operation. Not overridable.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_op  in  2  00 ADD (cin=0), 01 ADC (cin=req_cin), 10 SUB (A+~B+1), 11 SBC (A+~B+req_cin).
req_a  in  WIDTH  operand A.
req_b  in  WIDTH  operand B.
req_cin  in  1  carry/not-borrow input for ADC/SBC; ignored otherwise.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts result.
rsp_result  out  WIDTH  A op B.
rsp_cout  out  1  carry out of MSB; for SUB/SBC, 1 means no borrow.
rsp_zero  out  1  rsp_result == 0.
rsp_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, busy=0, rsp_result=0, rsp_cout=0, rsp_zero=0, rsp_ovf=0. Internal nibble index and carry registers clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch A; latch B (inverted when op[1]=1); latch initial carry per req_op; set idx=0; go to RUN.
  - Inputs are sampled only at this edge.
- RUN:
  - req_ready=0.
  - Each cycle the slice adds A[idx], B'[idx] and the carry register.
  - At the edge: result nibble idx is written, carry <= slice cout, idx++.
  - On the edge where idx==NIBBLES-1: also capture the slice's internal carry into bit 3 as msb_cin, then go to DONE.
- DONE:
  - rsp_valid=1. rsp_* are stable and registered, never combinational from the slice.
  - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid falls next cycle.
  - rsp_result and flags keep their last values until the next completion.
- Latency: rsp_valid rises exactly NIBBLES cycles after the accepting edge (4 for WIDTH=16). Minimum initiation interval is NIBBLES+2 cycles.
- req_valid while busy is ignored: no queuing, no error.
- rsp_ready held low stalls indefinitely in DONE; outputs and flags remain unchanged.
- Arithmetic is modulo 2^WIDTH. Flags are computed from the full result and final carries only; per-nibble flags are not exposed.
- Reset asserted mid-operation aborts immediately: no response is produced, and all outputs return to their reset values asynchronously.
- No X propagation: operand registers update only on accept.

Decomposition:
- Shared package (alu_pkg):
  - op encoding constants OP_ADD=2'b00, OP_ADC=2'b01, OP_SUB=2'b10, OP_SBC=2'b11.
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE.
  - NIBBLE_W=4.
- Sub-module nibble_addsub_slice: purely combinational 4-bit ripple adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout, c3 (carry into bit 3, needed for overflow).
  - The controller instantiates exactly one.
- Controller holds the operand, result, carry, index and state registers, and does the nibble muxing.

Test Plan:
1. ADD 0x1234+0x0FCD, rsp_ready=1 -> rsp_valid exactly 4 cycles after accept; result 0x2201, cout=0, zero=0, ovf=0; req_ready=0 throughout.
2. SUB 0x0005-0x0007 -> result 0xFFFE, cout=0 (borrow), ovf=0, zero=0. SUB 0x1234-0x1234 -> result 0x0000, cout=1, zero=1.
3. ADD 0x7FFF+0x0001 -> result 0x8000, ovf=1, cout=0. ADD 0xFFFF+0x0001 -> result 0x0000, cout=1, zero=1, ovf=0.
4. ADC 0x00FF+0x0000 with req_cin=1 -> result 0x0100. SBC 0x8000-0x0001 with req_cin=1 -> result 0x7FFF, ovf=1, cout=1. SBC with req_cin=0 -> result 0x7FFE.
5. Backpressure: hold rsp_ready=0 for 5 cycles in DONE while pulsing req_valid with new operands -> outputs stable, request ignored, busy=1. Release -> IDLE next cycle; the next request is accepted normally.
6. Assert rst_n=0 during RUN (after 2 nibbles) -> all outputs at reset values within the same cycle, no rsp_valid pulse. After release, ADD 0x0001+0x0001 -> 0x0002 with normal 4-cycle latency.
